keypad_scanner: RTL and testbench

//   Scans a 4x4 active-low matrix keypad, debounces press and release, and

---
 rtl/keypad_scanner_if.sv | 26 ++
 rtl/keypad_scanner.sv | 180 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: matrix rows/columns on the keypad side, key code and
// strobes on the consumer side. The scanner uses the master modport; the
// keypad/consumer environment uses the slave modport.
interface keypad_scanner_if;
    logic [3:0] row_in;     // keypad rows, active-low, asynchronous
    logic [3:0] col_drive;  // one-hot active-low column drive
    logic [3:0] key_code;   // last accepted key code
    logic       key_valid;  // one-cycle accept strobe
    logic       key_held;   // accepted key not yet released

    modport master (
        input  row_in,
        output col_drive,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row_in,
        input  col_drive,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press/release debounce.
// Emits one key_valid strobe and key code per physical press.
// Optional build macro KEYPAD_MULTIKEY_REJECT_EN: discard a press whenever
// more than one row reads low (ghosting guard). Undefined: lowest row wins.
module keypad_scanner #(
    parameter int SCAN_DIV     = 16,     // cycles per column before sampling (>=3)
    parameter int DEBOUNCE_CYC = 50000   // stable samples for press/release (>=2)
) (
    input  logic             clk,
    input  logic             rst_n,
    keypad_scanner_if.master bus
);

    localparam int MAXC = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_DONE  = CW'(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_MAX   = CW'(MAXC);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

`ifdef KEYPAD_MULTIKEY_REJECT_EN
    localparam bit MULTI_REJ = 1'b1;
`else
    localparam bit MULTI_REJ = 1'b0;
`endif

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t        state_q;
    logic [1:0]    col_q;
    logic [1:0]    row_q;
    logic [CW-1:0] scnt_q;
    logic [CW-1:0] dcnt_q;
    logic [CW-1:0] rcnt_q;
    logic [3:0]    coldrv_q;
    logic [3:0]    code_q;
    logic          valid_q;
    logic          held_q;
    logic [3:0]    sync1_q;
    logic [3:0]    sync2_q;

    logic [3:0]    row_s;
    logic [1:0]    col_next_d;
    logic [1:0]    low_row_d;
    logic          any_low_d;
    logic          multi_low_d;

    // Key legend for row r / column c; '0' key maps to code 0.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Lowest-numbered low (pressed) row.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        logic [1:0] r;
        casez (rows)
            4'b???0: r = 2'd0;
            4'b??01: r = 2'd1;
            4'b?011: r = 2'd2;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

    // Active-low one-hot column drive pattern.
    function automatic logic [3:0] col_pattern(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

    // Counter increment that sticks at its maximum instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign row_s       = sync2_q;
    assign col_next_d  = col_q + 2'd1;
    assign low_row_d   = lowest_low(row_s);
    assign any_low_d   = (row_s != 4'hF);
    assign multi_low_d = ((4'(~row_s[0]) + 4'(~row_s[1]) + 4'(~row_s[2]) + 4'(~row_s[3])) > 4'd1);

    assign bus.col_drive = coldrv_q;
    assign bus.key_code  = code_q;
    assign bus.key_valid = valid_q;
    assign bus.key_held  = held_q;

    // Two-flop synchronizer for the asynchronous row inputs (idle = all high).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= bus.row_in;
            sync2_q <= sync1_q;
        end
    end

    // Scan / debounce / held / release state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= SCAN;
            col_q    <= 2'd0;
            row_q    <= 2'd0;
            scnt_q   <= '0;
            dcnt_q   <= '0;
            rcnt_q   <= '0;
            coldrv_q <= 4'b1110;
            code_q   <= 4'h0;
            valid_q  <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (scnt_q == SCAN_LAST) begin
                        scnt_q <= '0;
                        if (any_low_d && !(MULTI_REJ && multi_low_d)) begin
                            row_q   <= low_row_d;
                            dcnt_q  <= CNT_ONE;
                            state_q <= DEBOUNCE;
                        end else begin
                            col_q    <= col_next_d;
                            coldrv_q <= col_pattern(col_next_d);
                        end
                    end else begin
                        scnt_q <= sat_inc(scnt_q);
                    end
                end
                DEBOUNCE: begin
                    if (row_s[row_q] || (MULTI_REJ && multi_low_d)) begin
                        // Bounce or ghost: drop the press and move on.
                        state_q  <= SCAN;
                        scnt_q   <= '0;
                        col_q    <= col_next_d;
                        coldrv_q <= col_pattern(col_next_d);
                    end else if (dcnt_q == DEB_DONE) begin
                        code_q  <= key_map(row_q, col_q);
                        valid_q <= 1'b1;
                        held_q  <= 1'b1;
                        state_q <= HELD;
                    end else begin
                        dcnt_q <= sat_inc(dcnt_q);
                    end
                end
                HELD: begin
                    if (row_s == 4'hF) begin
                        rcnt_q  <= CNT_ONE;
                        state_q <= RELEASE;
                    end
                end
                default: begin // RELEASE
                    if (row_s != 4'hF) begin
                        rcnt_q <= CNT_ONE;
                    end else if (rcnt_q == DEB_DONE) begin
                        held_q   <= 1'b0;
                        state_q  <= SCAN;
                        scnt_q   <= '0;
                        col_q    <= col_next_d;
                        coldrv_q <= col_pattern(col_next_d);
                    end else begin
                        rcnt_q <= sat_inc(rcnt_q);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CYC=8) with a
// behavioural 4x4 matrix model driving the rows from the column drive.
`timescale 1ns/1ps
module tb_keypad_scanner;

    logic        clk;
    logic        rst_n;
    logic [15:0] pressed;   // bit r*4+c = key at row r, column c pressed
    logic [3:0]  row_w;

    int          n_tests;
    int          n_fail;
    int          nstrobe;
    int          viol;
    int          base;
    logic [3:0]  code_log [64];
    logic        prev_kv;
    logic [3:0]  prev_code;
    logic [3:0]  prev_col;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CYC (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix model: a row reads low when a pressed key sits in a driven column.
    always_comb begin
        row_w = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kif.col_drive[c]) row_w[r] = 1'b0;
    end
    assign kif.row_in = row_w;

    // Strobe logger and output-rule monitor.
    initial begin
        nstrobe   = 0;
        viol      = 0;
        prev_kv   = 1'b0;
        prev_code = 4'h0;
    end
    always @(negedge clk) begin
        if (kif.key_valid) begin
            code_log[nstrobe % 64] = kif.key_code;
            nstrobe = nstrobe + 1;
            if (prev_kv) viol = viol + 1;
        end else if (rst_n && (kif.key_code != prev_code)) begin
            viol = viol + 1;
        end
        prev_kv   = kif.key_valid;
        prev_code = kif.key_code;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_strobe(input int target, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (nstrobe >= target) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         keys [4];
        logic [3:0] exp_codes [4];
        keys      = '{1, 1, 2, 4};
        exp_codes = '{4'h2, 4'h2, 4'h3, 4'h4};
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        pressed = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_col_drive", kif.col_drive, 4'b1110);
        check("rst_key_code",  kif.key_code,  4'h0);
        check("rst_key_valid", kif.key_valid, 1'b0);
        check("rst_key_held",  kif.key_held,  1'b0);

        // Short glitch on key '1': sampled, then aborted in debounce
        pressed[0] = 1'b1;
        rst_n      = 1'b1;
        repeat (3) @(negedge clk);
        pressed[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_col_adv", kif.col_drive, 4'b1101);
        check("glitch_strobes", nstrobe, 0);
        repeat (20) @(negedge clk);

        // Long press of '5' (r1/c1) and release debounce
        base       = nstrobe;
        pressed[5] = 1'b1;
        repeat (100) @(negedge clk);
        check("p5_strobes", nstrobe, base + 1);
        check("p5_code",    kif.key_code, 4'h5);
        check("p5_held",    kif.key_held, 1'b1);
        pressed[5] = 1'b0;
        repeat (6) @(negedge clk);
        check("p5_held_during_rel", kif.key_held, 1'b1);
        repeat (8) @(negedge clk);
        check("p5_held_after_rel",  kif.key_held, 1'b0);
        repeat (20) @(negedge clk);

        // Sequence 2,2,3,4
        base = nstrobe;
        for (int i = 0; i < 4; i++) begin
            pressed[keys[i]] = 1'b1;
            repeat (40) @(negedge clk);
            pressed[keys[i]] = 1'b0;
            repeat (40) @(negedge clk);
        end
        check("seq_strobes", nstrobe, base + 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("seq_code%0d", i), code_log[(base + i) % 64], exp_codes[i]);
        check("seq_held_idle", kif.key_held, 1'b0);

        // Bouncy release after accepting '9' (r2/c2)
        base        = nstrobe;
        pressed[10] = 1'b1;
        wait_strobe(base + 1, 80);
        check("bounce_first", nstrobe, base + 1);
        for (int i = 0; i < 3; i++) begin
            pressed[10] = 1'b0;
            repeat (2) @(negedge clk);
            pressed[10] = 1'b1;
            repeat (2) @(negedge clk);
        end
        pressed[10] = 1'b0;
        repeat (6) @(negedge clk);
        check("bounce_held_mid", kif.key_held, 1'b1);
        repeat (8) @(negedge clk);
        check("bounce_held_end", kif.key_held, 1'b0);
        check("bounce_no_second", nstrobe, base + 1);
        check("bounce_code", kif.key_code, 4'h9);
        repeat (10) @(negedge clk);

        // Reset in the middle of debounce on key '1'
        base     = nstrobe;
        prev_col = kif.col_drive;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (kif.col_drive == 4'b1110 && prev_col != 4'b1110) break;
            prev_col = kif.col_drive;
        end
        check("rstdb_sync_col", kif.col_drive, 4'b1110);
        pressed[0] = 1'b1;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstdb_col",   kif.col_drive, 4'b1110);
        check("rstdb_code",  kif.key_code,  4'h0);
        check("rstdb_held",  kif.key_held,  1'b0);
        check("rstdb_valid", kif.key_valid, 1'b0);
        @(negedge clk);
        pressed[0] = 1'b0;
        rst_n      = 1'b1;
        repeat (30) @(negedge clk);
        check("rstdb_strobes", nstrobe, base);

        // Two rows low in column 1 ('2' and '5')
        base       = nstrobe;
        pressed[1] = 1'b1;
        pressed[5] = 1'b1;
        repeat (100) @(negedge clk);
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        check("multi_strobes", nstrobe, base);
`else
        check("multi_strobes", nstrobe, base + 1);
        check("multi_code",    kif.key_code, 4'h2);
`endif
        pressed = '0;
        repeat (30) @(negedge clk);
        check("multi_held_end", kif.key_held, 1'b0);

        check("strobe_rules", viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
